// File: rtl/riscv_mem_stage_lsu_pkg.sv
// Shared RV32I funct3 / writeback-select constants and the MEM-stage LSU state type.
package riscv_mem_stage_lsu_pkg;

   localparam logic [2:0] LOAD_8        = 3'b000;
   localparam logic [2:0] LOAD_16       = 3'b001;
   localparam logic [2:0] LOAD_32       = 3'b010;
   localparam logic [2:0] LOAD_8_UNSGN  = 3'b100;
   localparam logic [2:0] LOAD_16_UNSGN = 3'b101;

   localparam logic [2:0] S_8  = 3'b000;
   localparam logic [2:0] S_16 = 3'b001;
   localparam logic [2:0] S_32 = 3'b010;

   localparam logic [1:0] RD_MEM_BYPASS_ALU       = 2'd0;
   localparam logic [1:0] RD_MEM_BYPASS_PC_PLUS_4 = 2'd1;
   localparam logic [1:0] RD_MEM_BYPASS_MEM_DATA  = 2'd2;

   localparam int unsigned LSU_DEFAULT_TIMEOUT = 255;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_GNT,
      WAIT_RSP
   } lsu_state_t;

endpackage

// File: rtl/riscv_lsu_align.sv
// Lane alignment for the LSU: request-side byte enables, store data and misalign/illegal
// detection from the incoming op; response-side load extraction from the latched op.
module riscv_lsu_align
   import riscv_mem_stage_lsu_pkg::*;
(
   input  logic [2:0]  req_funct3,
   input  logic        req_is_load,
   input  logic [1:0]  req_addr_lo,
   input  logic [31:0] req_rs2,
   output logic [3:0]  req_be,
   output logic [31:0] req_wdata,
   output logic        req_misaligned,
   input  logic [2:0]  rsp_funct3,
   input  logic [1:0]  rsp_addr_lo,
   input  logic [31:0] rsp_rdata,
   output logic [31:0] rsp_load_data
);

   logic        legal;
   logic        size_mis;
   logic [31:0] shifted;

   always_comb begin
      legal = 1'b0;
      if (req_is_load) begin
         case (req_funct3)
            LOAD_8, LOAD_16, LOAD_32, LOAD_8_UNSGN, LOAD_16_UNSGN: legal = 1'b1;
            default: legal = 1'b0;
         endcase
      end else begin
         case (req_funct3)
            S_8, S_16, S_32: legal = 1'b1;
            default: legal = 1'b0;
         endcase
      end
   end

   // Access size lives in funct3[1:0] for both loads and stores.
   always_comb begin
      req_be    = 4'b0000;
      req_wdata = req_rs2;
      size_mis  = 1'b1;
      case (req_funct3[1:0])
         2'b00: begin
            req_be    = 4'b0001 << req_addr_lo;
            req_wdata = {4{req_rs2[7:0]}};
            size_mis  = 1'b0;
         end
         2'b01: begin
            req_be    = 4'b0011 << req_addr_lo;
            req_wdata = {2{req_rs2[15:0]}};
            size_mis  = req_addr_lo[0];
         end
         2'b10: begin
            req_be    = 4'b1111;
            req_wdata = req_rs2;
            size_mis  = (req_addr_lo != 2'b00);
         end
         default: begin
            req_be    = 4'b0000;
            req_wdata = req_rs2;
            size_mis  = 1'b1;
         end
      endcase
      req_misaligned = ~legal | size_mis;
   end

   assign shifted = rsp_rdata >> {rsp_addr_lo, 3'b000};

   always_comb begin
      case (rsp_funct3)
         LOAD_8:        rsp_load_data = {{24{shifted[7]}}, shifted[7:0]};
         LOAD_16:       rsp_load_data = {{16{shifted[15]}}, shifted[15:0]};
         LOAD_8_UNSGN:  rsp_load_data = {24'h0, shifted[7:0]};
         LOAD_16_UNSGN: rsp_load_data = {16'h0, shifted[15:0]};
         default:       rsp_load_data = shifted;
      endcase
   end

endmodule

// File: rtl/riscv_mem_stage_lsu.sv
// RV32I MEM stage: non-mem ops pass through in 1 cycle; loads/stores run req/gnt/rvalid (>=2 cycles)
// while stall_o holds upstream; misaligned ops and bus timeouts retire with an exception pulse.
module riscv_mem_stage_lsu
   import riscv_mem_stage_lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = LSU_DEFAULT_TIMEOUT,
   parameter logic [4:0]  RESET_RD       = 5'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic        in_is_load,
   input  logic        in_is_store,
   input  logic [2:0]  in_funct3,
   input  logic [31:0] in_alu_res,
   input  logic [31:0] in_pc_plus4,
   input  logic [31:0] in_rs2,
   input  logic [4:0]  in_rd,
   input  logic        in_rd_we,
   input  logic [1:0]  in_rd_sel,
   output logic        stall_o,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        wb_valid,
   output logic        wb_we,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        exc_misalign,
   output logic        exc_bus_err
);

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   lsu_state_t  state_q, state_d;
   logic [15:0] tmo_cnt_q;
   logic        op_is_load_q, op_rd_we_q;
   logic [2:0]  op_funct3_q;
   logic [1:0]  op_addr_lo_q;
   logic [4:0]  op_rd_q;

   logic        mem_op, misaligned, issue, timeout, rsp_done;
   logic [3:0]  req_be;
   logic [31:0] req_wdata, load_data;

   riscv_lsu_align u_align (
      .req_funct3     (in_funct3),
      .req_is_load    (in_is_load),
      .req_addr_lo    (in_alu_res[1:0]),
      .req_rs2        (in_rs2),
      .req_be         (req_be),
      .req_wdata      (req_wdata),
      .req_misaligned (misaligned),
      .rsp_funct3     (op_funct3_q),
      .rsp_addr_lo    (op_addr_lo_q),
      .rsp_rdata      (mem_rdata),
      .rsp_load_data  (load_data)
   );

   assign mem_op   = in_valid & (in_is_load | in_is_store);
   assign issue    = (state_q == IDLE) & mem_op & ~misaligned;
   assign timeout  = (state_q != IDLE) & (tmo_cnt_q == TMO_LAST);
   // A grant that carries its response in the same cycle completes the op immediately.
   assign rsp_done = ((state_q == WAIT_GNT) & mem_gnt & mem_rvalid) |
                     ((state_q == WAIT_RSP) & mem_rvalid);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      stall_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (issue) begin
               state_d = WAIT_GNT;
               stall_o = 1'b1;
            end
         end
         WAIT_GNT: begin
            stall_o = ~rsp_done & ~timeout;
            if (rsp_done || timeout) state_d = IDLE;
            else if (mem_gnt)        state_d = WAIT_RSP;
         end
         WAIT_RSP: begin
            stall_o = ~rsp_done & ~timeout;
            if (rsp_done || timeout) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_be       <= 4'b0000;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         wb_valid     <= 1'b0;
         wb_we        <= 1'b0;
         wb_rd        <= RESET_RD;
         wb_data      <= '0;
         exc_misalign <= 1'b0;
         exc_bus_err  <= 1'b0;
         tmo_cnt_q    <= '0;
         op_is_load_q <= 1'b0;
         op_rd_we_q   <= 1'b0;
         op_funct3_q  <= '0;
         op_addr_lo_q <= '0;
         op_rd_q      <= '0;
      end else begin
         wb_valid     <= 1'b0;
         exc_misalign <= 1'b0;
         exc_bus_err  <= 1'b0;
         tmo_cnt_q    <= (state_q == IDLE) ? 16'd0 : tmo_cnt_q + 16'd1;

         if ((state_q == IDLE) && in_valid) begin
            if (issue) begin
               mem_req      <= 1'b1;
               mem_we       <= in_is_store;
               mem_be       <= req_be;
               mem_addr     <= {in_alu_res[31:2], 2'b00};
               mem_wdata    <= in_is_store ? req_wdata : 32'h0;
               op_is_load_q <= in_is_load;
               op_rd_we_q   <= in_rd_we;
               op_funct3_q  <= in_funct3;
               op_addr_lo_q <= in_alu_res[1:0];
               op_rd_q      <= in_rd;
            end else if (mem_op) begin
               wb_valid     <= 1'b1;
               wb_we        <= 1'b0;
               wb_rd        <= in_rd;
               exc_misalign <= 1'b1;
            end else begin
               wb_valid <= 1'b1;
               wb_we    <= in_rd_we & (in_rd != 5'd0);
               wb_rd    <= in_rd;
               wb_data  <= (in_rd_sel == RD_MEM_BYPASS_PC_PLUS_4) ? in_pc_plus4 : in_alu_res;
            end
         end

         if ((state_q == WAIT_GNT) && (mem_gnt || timeout)) mem_req <= 1'b0;

         if (rsp_done) begin
            wb_valid <= 1'b1;
            wb_rd    <= op_rd_q;
            wb_we    <= op_is_load_q & op_rd_we_q & (op_rd_q != 5'd0);
            if (op_is_load_q) wb_data <= load_data;
         end else if (timeout) begin
            wb_valid    <= 1'b1;
            wb_we       <= 1'b0;
            wb_rd       <= op_rd_q;
            exc_bus_err <= 1'b1;
         end
      end
   end

endmodule
